// File: rtl/redis_cache_obi_ctrl.sv
// OBI subordinate register front-end for the RedisCache core: KEY/VALUE/CMD/STATUS/RESULT
// registers and a single valid/ready command channel. Optional CTRL/irq via REDIS_CTRL_IRQ_EN.
module redis_cache_obi_ctrl #(
    parameter int unsigned IdWidth  = 1,
    parameter int unsigned KeyWidth = 32,
    parameter int unsigned ValWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                obi_req_i,
    output logic                obi_gnt_o,
    input  logic [31:0]         obi_addr_i,
    input  logic                obi_we_i,
    input  logic [3:0]          obi_be_i,
    input  logic [31:0]         obi_wdata_i,
    input  logic [IdWidth-1:0]  obi_aid_i,
    output logic                obi_rvalid_o,
    output logic [31:0]         obi_rdata_o,
    output logic                obi_err_o,
    output logic [IdWidth-1:0]  obi_rid_o,
    output logic                core_cmd_valid_o,
    input  logic                core_cmd_ready_i,
    output logic [1:0]          core_cmd_op_o,
    output logic [KeyWidth-1:0] core_cmd_key_o,
    output logic [ValWidth-1:0] core_cmd_value_o,
    input  logic                core_rsp_valid_i,
    input  logic                core_rsp_hit_i,
    input  logic [ValWidth-1:0] core_rsp_value_i,
    output logic                irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [2:0] OFF_KEY    = 3'd0;
    localparam logic [2:0] OFF_VALUE  = 3'd1;
    localparam logic [2:0] OFF_CMD    = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_RESULT = 3'd4;
    localparam logic [2:0] OFF_CTRL   = 3'd5;
    localparam logic [1:0] OP_GET     = 2'd1;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    state_e                state_r;
    state_e                state_s;
    logic [KeyWidth-1:0]   key_r;
    logic [ValWidth-1:0]   val_r;
    logic [1:0]            cmd_op_r;
    logic [KeyWidth-1:0]   cmd_key_r;
    logic [ValWidth-1:0]   cmd_val_r;
    logic                  cmd_valid_r;
    logic                  hit_r;
    logic                  done_r;
    logic [ValWidth-1:0]   result_r;
    logic                  rvalid_r;
    logic [31:0]           rdata_r;
    logic                  err_r;
    logic [IdWidth-1:0]    rid_r;

    logic [2:0]            addr_idx_s;
    logic                  busy_s;
    logic                  rsp_done_s;
    logic [31:0]           rsp_rdata_s;
    logic                  rsp_err_s;
    logic                  key_we_s;
    logic                  val_we_s;
    logic                  cmd_start_s;
    logic                  status_rd_s;
    logic                  ctrl_we_s;
    logic [31:0]           key_merged_s;
    logic [31:0]           val_merged_s;
    logic                  unused_addr_s;

    assign addr_idx_s    = obi_addr_i[4:2];
    assign busy_s        = (state_r != ST_IDLE);
    assign rsp_done_s    = (state_r == ST_WAIT) && core_rsp_valid_i;
    assign key_merged_s  = be_merge(32'(key_r), obi_wdata_i, obi_be_i);
    assign val_merged_s  = be_merge(32'(val_r), obi_wdata_i, obi_be_i);
    assign unused_addr_s = ^{obi_addr_i[31:5], obi_addr_i[1:0]};

    assign obi_gnt_o        = obi_req_i;
    assign obi_rvalid_o     = rvalid_r;
    assign obi_rdata_o      = rdata_r;
    assign obi_err_o        = err_r;
    assign obi_rid_o        = rid_r;
    assign core_cmd_valid_o = cmd_valid_r;
    assign core_cmd_op_o    = cmd_op_r;
    assign core_cmd_key_o   = cmd_key_r;
    assign core_cmd_value_o = cmd_val_r;

`ifdef REDIS_CTRL_IRQ_EN
    logic ie_r;
    logic irq_r;

    // Interrupt enable register and registered completion interrupt
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ie_r  <= 1'b0;
            irq_r <= 1'b0;
        end else begin
            if (ctrl_we_s && obi_be_i[0]) begin
                ie_r <= obi_wdata_i[0];
            end else begin
                ie_r <= ie_r;
            end
            irq_r <= done_r & ie_r;
        end
    end

    assign irq_o = irq_r;
`else
    assign irq_o = 1'b0;
`endif

    // Address decode: read data, access errors and per-register write strobes
    always_comb begin
        rsp_rdata_s = 32'd0;
        rsp_err_s   = 1'b0;
        key_we_s    = 1'b0;
        val_we_s    = 1'b0;
        cmd_start_s = 1'b0;
        status_rd_s = 1'b0;
        ctrl_we_s   = 1'b0;
        case (addr_idx_s)
            OFF_KEY: begin
                if (obi_we_i) begin
                    rsp_err_s = busy_s;
                    key_we_s  = obi_req_i && !busy_s;
                end else begin
                    rsp_rdata_s = 32'(key_r);
                end
            end
            OFF_VALUE: begin
                if (obi_we_i) begin
                    rsp_err_s = busy_s;
                    val_we_s  = obi_req_i && !busy_s;
                end else begin
                    rsp_rdata_s = 32'(val_r);
                end
            end
            OFF_CMD: begin
                if (obi_we_i) begin
                    // op=0 is not a command; a busy controller refuses new ones
                    rsp_err_s   = busy_s || (obi_wdata_i[1:0] == 2'd0);
                    cmd_start_s = obi_req_i && !busy_s && (obi_wdata_i[1:0] != 2'd0);
                end else begin
                    rsp_rdata_s = {30'd0, cmd_op_r};
                end
            end
            OFF_STATUS: begin
                if (obi_we_i) begin
                    rsp_err_s = 1'b1;
                end else begin
                    rsp_rdata_s = {29'd0, done_r, hit_r, busy_s};
                    status_rd_s = obi_req_i;
                end
            end
            OFF_RESULT: begin
                if (obi_we_i) begin
                    rsp_err_s = 1'b1;
                end else begin
                    rsp_rdata_s = 32'(result_r);
                end
            end
            OFF_CTRL: begin
`ifdef REDIS_CTRL_IRQ_EN
                if (obi_we_i) begin
                    ctrl_we_s = obi_req_i;
                end else begin
                    rsp_rdata_s = {31'd0, ie_r};
                end
`else
                rsp_err_s = 1'b1;
`endif
            end
            default: begin
                rsp_err_s = 1'b1;
            end
        endcase
    end

    // Next-state logic for the command FSM
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_start_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (core_cmd_ready_i) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (core_rsp_valid_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered OBI response, one cycle after each granted request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            err_r    <= 1'b0;
            rid_r    <= '0;
        end else if (obi_req_i) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rsp_rdata_s;
            err_r    <= rsp_err_s;
            rid_r    <= obi_aid_i;
        end else begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            err_r    <= 1'b0;
            rid_r    <= rid_r;
        end
    end

    // Software-visible KEY/VALUE registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_r <= '0;
            val_r <= '0;
        end else begin
            if (key_we_s) begin
                key_r <= key_merged_s[KeyWidth-1:0];
            end else begin
                key_r <= key_r;
            end
            if (val_we_s) begin
                val_r <= val_merged_s[ValWidth-1:0];
            end else begin
                val_r <= val_r;
            end
        end
    end

    // Command snapshot, valid strobe and response capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_op_r    <= 2'd0;
            cmd_key_r   <= '0;
            cmd_val_r   <= '0;
            cmd_valid_r <= 1'b0;
            hit_r       <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= '0;
        end else begin
            if (cmd_start_s) begin
                cmd_op_r  <= obi_wdata_i[1:0];
                cmd_key_r <= key_r;
                cmd_val_r <= val_r;
            end else begin
                cmd_op_r  <= cmd_op_r;
                cmd_key_r <= cmd_key_r;
                cmd_val_r <= cmd_val_r;
            end
            cmd_valid_r <= (state_s == ST_ISSUE);
            // A completing response wins over a same-cycle STATUS read clear
            if (rsp_done_s) begin
                done_r <= 1'b1;
                hit_r  <= core_rsp_hit_i;
            end else if (cmd_start_s || status_rd_s) begin
                done_r <= 1'b0;
                hit_r  <= hit_r;
            end else begin
                done_r <= done_r;
                hit_r  <= hit_r;
            end
            if (rsp_done_s && (cmd_op_r == OP_GET)) begin
                result_r <= core_rsp_value_i;
            end else begin
                result_r <= result_r;
            end
        end
    end

endmodule

// File: tb/tb_redis_cache_obi_ctrl.sv
// Directed self-checking bench for redis_cache_obi_ctrl: register map, command FSM,
// error responses, response races and (under REDIS_CTRL_IRQ_EN) the interrupt.
module tb_redis_cache_obi_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        obi_req = 1'b0;
    logic        obi_gnt;
    logic [31:0] obi_addr = 32'd0;
    logic        obi_we = 1'b0;
    logic [3:0]  obi_be = 4'd0;
    logic [31:0] obi_wdata = 32'd0;
    logic [0:0]  obi_aid = 1'b0;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic        obi_err;
    logic [0:0]  obi_rid;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_key;
    logic [31:0] cmd_value;
    logic        rsp_valid = 1'b0;
    logic        rsp_hit = 1'b0;
    logic [31:0] rsp_value = 32'd0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A_KEY    = 32'h00;
    localparam logic [31:0] A_VALUE  = 32'h04;
    localparam logic [31:0] A_CMD    = 32'h08;
    localparam logic [31:0] A_STATUS = 32'h0C;
    localparam logic [31:0] A_RESULT = 32'h10;
    localparam logic [31:0] A_CTRL   = 32'h14;

    redis_cache_obi_ctrl #(.IdWidth(1), .KeyWidth(32), .ValWidth(32)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .obi_req_i        (obi_req),
        .obi_gnt_o        (obi_gnt),
        .obi_addr_i       (obi_addr),
        .obi_we_i         (obi_we),
        .obi_be_i         (obi_be),
        .obi_wdata_i      (obi_wdata),
        .obi_aid_i        (obi_aid),
        .obi_rvalid_o     (obi_rvalid),
        .obi_rdata_o      (obi_rdata),
        .obi_err_o        (obi_err),
        .obi_rid_o        (obi_rid),
        .core_cmd_valid_o (cmd_valid),
        .core_cmd_ready_i (cmd_ready),
        .core_cmd_op_o    (cmd_op),
        .core_cmd_key_o   (cmd_key),
        .core_cmd_value_o (cmd_value),
        .core_rsp_valid_i (rsp_valid),
        .core_rsp_hit_i   (rsp_hit),
        .core_rsp_value_i (rsp_value),
        .irq_o            (irq)
    );

    always #5 clk = ~clk;

    // One OBI transfer; called at posedge+1, returns at the next posedge+1 with the response
    task automatic obi_access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [0:0] aid,
                              output logic [31:0] rdata, output logic err,
                              output logic [0:0] rid, output logic rvalid);
        obi_req   = 1'b1;
        obi_addr  = addr;
        obi_we    = we;
        obi_be    = be;
        obi_wdata = wdata;
        obi_aid   = aid;
        @(posedge clk);
        #1;
        obi_req = 1'b0;
        obi_we  = 1'b0;
        rdata   = obi_rdata;
        err     = obi_err;
        rid     = obi_rid;
        rvalid  = obi_rvalid;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; logic [0:0] id; logic rv;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({cmd_valid, cmd_op, irq, obi_rvalid, obi_err} !== 6'd0 || obi_rdata !== 32'd0 || obi_rid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b op=%0d irq=%b rvalid=%b err=%b rdata=%h rid=%b, all required 0",
                     cmd_valid, cmd_op, irq, obi_rvalid, obi_err, obi_rdata, obi_rid);
        end
        obi_req = 1'b1;
        #1;
        checks++;
        if (obi_gnt !== 1'b1) begin
            errors++;
            $display("FAIL gnt_follows_req: got %b required 1", obi_gnt);
        end
        obi_access(A_STATUS, 1'b0, 4'hF, 32'd0, 1'b1, rd, er, id, rv);
        checks++;
        if (rv !== 1'b1 || rd !== 32'd0 || er !== 1'b0 || id !== 1'b1) begin
            errors++;
            $display("FAIL reset_status_read: rvalid=%b rdata=%h err=%b rid=%b, required 1/00000000/0/1", rv, rd, er, id);
        end
        step();
        checks++;
        if (obi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_single_cycle: got %b required 0", obi_rvalid);
        end
    endtask

    // Issue CMD=op and act as core: ready after ready_dly cycles, response rsp_dly cycles later
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val,
                           input int ready_dly, input int rsp_dly, input logic hit, input logic [31:0] rval);
        logic [31:0] rd; logic er; logic [0:0] id; logic rv;
        obi_access(A_CMD, 1'b1, 4'hF, {30'd0, op}, 1'b0, rd, er, id, rv);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL cmd_write_err: got %b required 0", er);
        end
        for (int i = 0; i <= ready_dly; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_op !== op || cmd_key !== key || cmd_value !== val) begin
                errors++;
                $display("FAIL cmd_issue[%0d]: valid=%b op=%0d key=%h value=%h, required 1/%0d/%h/%h",
                         i, cmd_valid, cmd_op, cmd_key, cmd_value, op, key, val);
            end
            if (i < ready_dly) step();
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL cmd_valid_drop: got %b required 0", cmd_valid);
        end
        repeat (rsp_dly) step();
        rsp_valid = 1'b1;
        rsp_hit   = hit;
        rsp_value = rval;
        step();
        rsp_valid = 1'b0;
        rsp_hit   = 1'b0;
        rsp_value = 32'd0;
    endtask

    task automatic test_put();
        logic [31:0] rd; logic er; logic [0:0] id; logic rv;
        obi_access(A_KEY, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, rd, er, id, rv);
        obi_access(A_VALUE, 1'b1, 4'hF, 32'h12345678, 1'b0, rd, er, id, rv);
        run_cmd(2'd2, 32'hDEADBEEF, 32'h12345678, 3, 2, 1'b1, 32'h0);
        obi_access(A_STATUS, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h6 || er !== 1'b0) begin
            errors++;
            $display("FAIL put_status_first: rdata=%h err=%b, required 00000006/0", rd, er);
        end
        obi_access(A_STATUS, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL put_status_second: rdata=%h required 00000002", rd);
        end
    endtask

    task automatic test_get();
        logic [31:0] rd; logic er; logic [0:0] id; logic rv;
        run_cmd(2'd1, 32'hDEADBEEF, 32'h12345678, 0, 0, 1'b1, 32'hCAFEF00D);
        obi_access(A_RESULT, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL get_result: rdata=%h err=%b, required cafef00d/0", rd, er);
        end
        obi_access(A_CMD, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL get_cmd_readback: rdata=%h required 00000001", rd);
        end
    endtask

    task automatic test_busy();
        logic [31:0] rd; logic er; logic [0:0] id; logic rv;
        obi_access(A_CMD, 1'b1, 4'hF, 32'd3, 1'b0, rd, er, id, rv);
        obi_access(A_KEY, 1'b1, 4'hF, 32'h1, 1'b0, rd, er, id, rv);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL busy_key_write_err: got %b required 1", er);
        end
        obi_access(A_KEY, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL busy_key_kept: rdata=%h err=%b, required deadbeef/0", rd, er);
        end
        obi_access(32'h18, 1'b1, 4'hF, 32'h5, 1'b0, rd, er, id, rv);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL bad_offset_18: err=%b rdata=%h, required 1/00000000", er, rd);
        end
        obi_access(A_CMD, 1'b1, 4'hF, 32'd1, 1'b0, rd, er, id, rv);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL busy_cmd_write_err: got %b required 1", er);
        end
        // Stray response while still in ISSUE must not complete the command
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        obi_access(A_STATUS, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h3 || cmd_valid !== 1'b1 || cmd_op !== 2'd3) begin
            errors++;
            $display("FAIL busy_status: rdata=%h valid=%b op=%0d, required 00000003/1/3", rd, cmd_valid, cmd_op);
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_hit   = 1'b0;
        step();
        rsp_valid = 1'b0;
        obi_access(A_STATUS, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL del_miss_status: rdata=%h required 00000004", rd);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; logic [0:0] id; logic rv;
        obi_access(A_VALUE, 1'b1, 4'hF, 32'h0, 1'b0, rd, er, id, rv);
        obi_access(A_VALUE, 1'b1, 4'b0010, 32'h0000AB00, 1'b0, rd, er, id, rv);
        obi_access(A_VALUE, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h0000AB00) begin
            errors++;
            $display("FAIL be_byte1: rdata=%h required 0000ab00", rd);
        end
        obi_access(A_VALUE, 1'b1, 4'b1000, 32'h11223344, 1'b0, rd, er, id, rv);
        obi_access(A_VALUE, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h1100AB00) begin
            errors++;
            $display("FAIL be_byte3: rdata=%h required 1100ab00", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; logic [0:0] id; logic rv;
        obi_access(A_CMD, 1'b1, 4'hF, 32'h0, 1'b0, rd, er, id, rv);
        checks++;
        if (er !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL cmd_op0: err=%b valid=%b, required 1/0", er, cmd_valid);
        end
        obi_access(A_CMD, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL cmd_op0_no_update: rdata=%h required 00000003", rd);
        end
        obi_access(A_STATUS, 1'b1, 4'hF, 32'h7, 1'b0, rd, er, id, rv);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL status_write_err: got %b required 1", er);
        end
        obi_access(A_RESULT, 1'b1, 4'hF, 32'h0, 1'b0, rd, er, id, rv);
        obi_access(A_RESULT, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL result_write_ignored: rdata=%h required cafef00d", rd);
        end
        obi_access(32'h1C, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL bad_offset_1c: err=%b rdata=%h, required 1/00000000", er, rd);
        end
    endtask

    task automatic test_rsp_race();
        logic [31:0] rd; logic er; logic [0:0] id; logic rv;
        obi_access(A_CMD, 1'b1, 4'hF, 32'd1, 1'b0, rd, er, id, rv);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_hit   = 1'b1;
        rsp_value = 32'h55AA55AA;
        obi_access(A_STATUS, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        rsp_valid = 1'b0;
        rsp_hit   = 1'b0;
        rsp_value = 32'd0;
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL race_pre_update: rdata=%h required 00000001", rd);
        end
        obi_access(A_STATUS, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h6) begin
            errors++;
            $display("FAIL race_done_set_wins: rdata=%h required 00000006", rd);
        end
        obi_access(A_RESULT, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL race_result: rdata=%h required 55aa55aa", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd0, rd1; logic er0, er1; logic [0:0] id0, id1; logic rv0, rv1;
        obi_access(A_KEY, 1'b0, 4'hF, 32'd0, 1'b0, rd0, er0, id0, rv0);
        obi_access(A_VALUE, 1'b0, 4'hF, 32'd0, 1'b1, rd1, er1, id1, rv1);
        checks++;
        if (rv0 !== 1'b1 || rd0 !== 32'hDEADBEEF || id0 !== 1'b0 || er0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: rvalid=%b rdata=%h rid=%b err=%b, required 1/deadbeef/0/0", rv0, rd0, id0, er0);
        end
        checks++;
        if (rv1 !== 1'b1 || rd1 !== 32'h1100AB00 || id1 !== 1'b1 || er1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: rvalid=%b rdata=%h rid=%b err=%b, required 1/1100ab00/1/0", rv1, rd1, id1, er1);
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic er; logic [0:0] id; logic rv;
`ifdef REDIS_CTRL_IRQ_EN
        obi_access(A_CTRL, 1'b1, 4'hF, 32'h1, 1'b0, rd, er, id, rv);
        obi_access(A_CTRL, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h1 || er !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_readback: rdata=%h err=%b, required 00000001/0", rd, er);
        end
        run_cmd(2'd3, 32'hDEADBEEF, 32'h1100AB00, 1, 1, 1'b1, 32'h0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_not_early: got %b required 0", irq);
        end
        step();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_asserted: got %b required 1", irq);
        end
        obi_access(A_STATUS, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        step();
        checks++;
        if (irq !== 1'b0 || rd !== 32'h6) begin
            errors++;
            $display("FAIL irq_cleared: irq=%b status=%h, required 0/00000006", irq, rd);
        end
`else
        obi_access(A_CTRL, 1'b1, 4'hF, 32'h1, 1'b0, rd, er, id, rv);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL ctrl_write_err: got %b required 1", er);
        end
        obi_access(A_CTRL, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL ctrl_read_err: err=%b rdata=%h, required 1/00000000", er, rd);
        end
        run_cmd(2'd3, 32'hDEADBEEF, 32'h1100AB00, 1, 1, 1'b1, 32'h0);
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_tied_low: got %b required 0", irq);
        end
`endif
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd; logic er; logic [0:0] id; logic rv;
        obi_access(A_CMD, 1'b1, 4'hF, 32'd2, 1'b0, rd, er, id, rv);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_op !== 2'd0) begin
            errors++;
            $display("FAIL midop_reset_valid: valid=%b op=%0d, required 0/0", cmd_valid, cmd_op);
        end
        rsp_valid = 1'b1;
        rsp_hit   = 1'b1;
        step();
        rsp_valid = 1'b0;
        rsp_hit   = 1'b0;
        obi_access(A_STATUS, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL midop_reset_status: rdata=%h required 00000000", rd);
        end
        obi_access(A_KEY, 1'b0, 4'hF, 32'd0, 1'b0, rd, er, id, rv);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL midop_reset_key: rdata=%h required 00000000", rd);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_put();
        test_get();
        test_busy();
        test_byte_enable();
        test_errors();
        test_rsp_race();
        test_back_to_back();
        test_irq();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
